// File: rtl/cdb_arbiter_if.sv
// Handshake and broadcast bundle for cdb_arbiter: ALU and LSB requesters in, CDB broadcast out.
// The slave modport is the arbiter side and the master modport is the requester/consumer side.
interface cdb_arbiter_if #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
);
    logic              alu_valid;
    logic              alu_ready;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_val;
    logic [DATA_W-1:0] alu_npc;
    logic              lsb_valid;
    logic              lsb_ready;
    logic [TAG_W-1:0]  lsb_tag;
    logic [DATA_W-1:0] lsb_val;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_val;
    logic [DATA_W-1:0] cdb_npc;
    logic              cdb_src;

    modport slave (
        input  alu_valid, alu_tag, alu_val, alu_npc, lsb_valid, lsb_tag, lsb_val,
        output alu_ready, lsb_ready, cdb_valid, cdb_tag, cdb_val, cdb_npc, cdb_src
    );

    modport master (
        output alu_valid, alu_tag, alu_val, alu_npc, lsb_valid, lsb_tag, lsb_val,
        input  alu_ready, lsb_ready, cdb_valid, cdb_tag, cdb_val, cdb_npc, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two per-requester FIFOs (ALU, LSB) feeding one registered broadcast.
// Define CDB_ROUND_ROBIN_EN for round-robin grant; default build gives the ALU fixed priority.
module cdb_arbiter #(
    parameter int TAG_W      = 5,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    input  logic           clear,
    cdb_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [TAG_W-1:0]  alu_tag_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] alu_val_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] alu_npc_mem [FIFO_DEPTH];
    logic [TAG_W-1:0]  lsb_tag_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] lsb_val_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  alu_wr_ptr_r, alu_rd_ptr_r, lsb_wr_ptr_r, lsb_rd_ptr_r;
    logic [CNT_W-1:0]  alu_cnt_r, lsb_cnt_r;
    logic              cdb_valid_r, cdb_src_r;
    logic [TAG_W-1:0]  cdb_tag_r;
    logic [DATA_W-1:0] cdb_val_r, cdb_npc_r;
`ifdef CDB_ROUND_ROBIN_EN
    logic              last_alu_r;
`endif

    logic enable_s, alu_ready_s, lsb_ready_s, alu_push_s, lsb_push_s;
    logic alu_pop_s, lsb_pop_s, alu_first_s, alu_ne_s, lsb_ne_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Handshake and grant decode; ready depends only on registered counts and the global controls.
    always_comb begin
        enable_s    = rst_in && rdy_in && !clear;
        alu_ne_s    = (alu_cnt_r != {CNT_W{1'b0}});
        lsb_ne_s    = (lsb_cnt_r != {CNT_W{1'b0}});
        alu_ready_s = enable_s && (alu_cnt_r < DEPTH_C);
        lsb_ready_s = enable_s && (lsb_cnt_r < DEPTH_C);
        alu_push_s  = alu_ready_s && bus.alu_valid && (bus.alu_tag != {TAG_W{1'b0}});
        lsb_push_s  = lsb_ready_s && bus.lsb_valid && (bus.lsb_tag != {TAG_W{1'b0}});
`ifdef CDB_ROUND_ROBIN_EN
        alu_first_s = !last_alu_r;
`else
        alu_first_s = 1'b1;
`endif
        alu_pop_s   = enable_s && alu_ne_s && (!lsb_ne_s || alu_first_s);
        lsb_pop_s   = enable_s && lsb_ne_s && !alu_pop_s;
    end

    assign bus.alu_ready = alu_ready_s;
    assign bus.lsb_ready = lsb_ready_s;
    assign bus.cdb_valid = cdb_valid_r;
    assign bus.cdb_tag   = cdb_tag_r;
    assign bus.cdb_val   = cdb_val_r;
    assign bus.cdb_npc   = cdb_npc_r;
    assign bus.cdb_src   = cdb_src_r;

    // FIFO payload storage; only written on an accepted non-zero-tag push.
    always_ff @(posedge clk_in) begin
        if (alu_push_s) begin
            alu_tag_mem[alu_wr_ptr_r] <= bus.alu_tag;
            alu_val_mem[alu_wr_ptr_r] <= bus.alu_val;
            alu_npc_mem[alu_wr_ptr_r] <= bus.alu_npc;
        end
        if (lsb_push_s) begin
            lsb_tag_mem[lsb_wr_ptr_r] <= bus.lsb_tag;
            lsb_val_mem[lsb_wr_ptr_r] <= bus.lsb_val;
        end
    end

    // Pointers, counts, grant history and broadcast register; reset beats clear beats stall.
    always_ff @(posedge clk_in) begin
        if (!rst_in || clear) begin
            alu_wr_ptr_r <= {PTR_W{1'b0}};
            alu_rd_ptr_r <= {PTR_W{1'b0}};
            lsb_wr_ptr_r <= {PTR_W{1'b0}};
            lsb_rd_ptr_r <= {PTR_W{1'b0}};
            alu_cnt_r    <= {CNT_W{1'b0}};
            lsb_cnt_r    <= {CNT_W{1'b0}};
            cdb_valid_r  <= 1'b0;
            cdb_src_r    <= 1'b0;
            cdb_tag_r    <= {TAG_W{1'b0}};
            cdb_val_r    <= {DATA_W{1'b0}};
            cdb_npc_r    <= {DATA_W{1'b0}};
`ifdef CDB_ROUND_ROBIN_EN
            last_alu_r   <= 1'b0;
`endif
        end else if (rdy_in) begin
            if (alu_push_s) alu_wr_ptr_r <= ptr_inc(alu_wr_ptr_r);
            if (alu_pop_s)  alu_rd_ptr_r <= ptr_inc(alu_rd_ptr_r);
            if (lsb_push_s) lsb_wr_ptr_r <= ptr_inc(lsb_wr_ptr_r);
            if (lsb_pop_s)  lsb_rd_ptr_r <= ptr_inc(lsb_rd_ptr_r);
            case ({alu_push_s, alu_pop_s})
                2'b10:   alu_cnt_r <= alu_cnt_r + CNT_W'(1);
                2'b01:   alu_cnt_r <= alu_cnt_r - CNT_W'(1);
                default: alu_cnt_r <= alu_cnt_r;
            endcase
            case ({lsb_push_s, lsb_pop_s})
                2'b10:   lsb_cnt_r <= lsb_cnt_r + CNT_W'(1);
                2'b01:   lsb_cnt_r <= lsb_cnt_r - CNT_W'(1);
                default: lsb_cnt_r <= lsb_cnt_r;
            endcase
`ifdef CDB_ROUND_ROBIN_EN
            if (alu_pop_s || lsb_pop_s) last_alu_r <= alu_pop_s;
`endif
            if (alu_pop_s) begin
                cdb_valid_r <= 1'b1;
                cdb_src_r   <= 1'b0;
                cdb_tag_r   <= alu_tag_mem[alu_rd_ptr_r];
                cdb_val_r   <= alu_val_mem[alu_rd_ptr_r];
                cdb_npc_r   <= alu_npc_mem[alu_rd_ptr_r];
            end else if (lsb_pop_s) begin
                cdb_valid_r <= 1'b1;
                cdb_src_r   <= 1'b1;
                cdb_tag_r   <= lsb_tag_mem[lsb_rd_ptr_r];
                cdb_val_r   <= lsb_val_mem[lsb_rd_ptr_r];
                cdb_npc_r   <= {DATA_W{1'b0}};
            end else begin
                cdb_valid_r <= 1'b0;
                cdb_src_r   <= 1'b0;
                cdb_tag_r   <= {TAG_W{1'b0}};
                cdb_val_r   <= {DATA_W{1'b0}};
                cdb_npc_r   <= {DATA_W{1'b0}};
            end
        end else begin
            cdb_valid_r <= cdb_valid_r;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected broadcasts are queued as stimulus is driven and
// checked every cycle against the CDB outputs; stalled cycles must repeat the previous broadcast.
module tb_cdb_arbiter;
    localparam int TW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic          valid;
        logic          src;
        logic [TW-1:0] tag;
        logic [DW-1:0] val;
        logic [DW-1:0] npc;
    } bc_t;

    logic clk = 1'b0;
    logic rst_in, rdy_in, clear;
    int   total = 0;
    int   bad   = 0;
    bc_t  exp_q[$];
    bc_t  last_exp;

    cdb_arbiter_if #(.TAG_W(TW), .DATA_W(DW)) bus ();

    cdb_arbiter #(.TAG_W(TW), .DATA_W(DW), .FIFO_DEPTH(2)) dut (
        .clk_in (clk),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clear  (clear),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic bc_t mk(input int src, input int tag, input int val, input int npc);
        bc_t b;
        b.valid = 1'b1;
        b.src   = src[0];
        b.tag   = tag[TW-1:0];
        b.val   = val;
        b.npc   = (src != 0) ? 32'h0 : npc;
        return b;
    endfunction

    // One clock edge, then compare the broadcast against the scoreboard.
    task automatic tick(input string nm);
        logic rst_e, clr_e, rdy_e;
        bc_t  obs, exp;
        rst_e = rst_in; clr_e = clear; rdy_e = rdy_in;
        @(posedge clk);
        #1;
        obs = {bus.cdb_valid, bus.cdb_src, bus.cdb_tag, bus.cdb_val, bus.cdb_npc};
        exp = '0;
        if (rst_e === 1'b0 || clr_e === 1'b1) exp = '0;
        else if (rdy_e === 1'b0) exp = last_exp;
        else if (obs.valid === 1'b1 && exp_q.size() != 0) exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got v=%0d src=%0d tag=%0d val=%h npc=%h required v=%0d src=%0d tag=%0d val=%h npc=%h",
                     nm, obs.valid, obs.src, obs.tag, obs.val, obs.npc,
                     exp.valid, exp.src, exp.tag, exp.val, exp.npc);
        end
        last_exp = exp;
    endtask

    task automatic chk_ready(input string nm, input logic a_exp, input logic l_exp);
        total++;
        if ({bus.alu_ready, bus.lsb_ready} !== {a_exp, l_exp}) begin
            bad++;
            $display("FAIL %s: got alu_ready=%b lsb_ready=%b required %b %b",
                     nm, bus.alu_ready, bus.lsb_ready, a_exp, l_exp);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick("drain");
            n++;
        end
        tick("idle");
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic set_alu(input logic v, input int tag, input int val, input int npc);
        bus.alu_valid = v; bus.alu_tag = tag[TW-1:0]; bus.alu_val = val; bus.alu_npc = npc;
    endtask

    task automatic set_lsb(input logic v, input int tag, input int val);
        bus.lsb_valid = v; bus.lsb_tag = tag[TW-1:0]; bus.lsb_val = val;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        set_alu(1'b1, 7, 32'h77, 32'h700);
        set_lsb(1'b1, 9, 32'h99);
        for (int i = 0; i < 2; i++) begin
            tick("reset_cdb");
            chk_ready("reset_ready", 1'b0, 1'b0);
        end
        set_alu(1'b0, 0, 0, 0);
        set_lsb(1'b0, 0, 0);
        rst_in = 1'b1;
        #1;
        chk_ready("post_reset_ready", 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick("post_reset_idle");
    endtask

    task automatic test_single();
        set_alu(1'b1, 3, 32'h1234, 32'h100);
        chk_ready("single_ready", 1'b1, 1'b1);
        exp_q.push_back(mk(0, 3, 32'h1234, 32'h100));
        tick("single_accept");
        set_alu(1'b0, 0, 0, 0);
        tick("single_bcast");
        total++;
        if (bus.cdb_valid !== 1'b1) begin
            bad++;
            $display("FAIL single_latency: got cdb_valid=%b required 1", bus.cdb_valid);
        end
        tick("single_after");
        drain(4);
    endtask

    task automatic test_contention();
`ifdef CDB_ROUND_ROBIN_EN
        exp_q.push_back(mk(0, 1, 32'h111, 32'h10));
        exp_q.push_back(mk(1, 5, 32'h555, 0));
        exp_q.push_back(mk(0, 2, 32'h222, 32'h20));
        exp_q.push_back(mk(1, 6, 32'h666, 0));
`else
        exp_q.push_back(mk(0, 1, 32'h111, 32'h10));
        exp_q.push_back(mk(0, 2, 32'h222, 32'h20));
        exp_q.push_back(mk(1, 5, 32'h555, 0));
        exp_q.push_back(mk(1, 6, 32'h666, 0));
`endif
        set_alu(1'b1, 1, 32'h111, 32'h10);
        set_lsb(1'b1, 5, 32'h555);
        tick("cont_push1");
        chk_ready("cont_ready2", 1'b1, 1'b1);
        set_alu(1'b1, 2, 32'h222, 32'h20);
        set_lsb(1'b1, 6, 32'h666);
        tick("cont_push2");
        set_alu(1'b0, 0, 0, 0);
        set_lsb(1'b0, 0, 0);
        drain(10);
    endtask

`ifndef CDB_ROUND_ROBIN_EN
    task automatic test_full();
        bc_t lq[$];
        for (int i = 0; i < 6; i++) begin
            set_alu(1'b1, i + 1, 32'hA00 + i, 32'h400 + 4 * i);
            exp_q.push_back(mk(0, i + 1, 32'hA00 + i, 32'h400 + 4 * i));
            set_lsb(1'b1, 10 + ((i < 2) ? i : 2), 32'hB00 + ((i < 2) ? i : 2));
            if (i < 3) lq.push_back(mk(1, 10 + i, 32'hB00 + i, 0));
            chk_ready("full_ready", 1'b1, (i < 2) ? 1'b1 : 1'b0);
            tick("full_alu");
        end
        set_alu(1'b0, 0, 0, 0);
        while (lq.size() != 0) exp_q.push_back(lq.pop_front());
        chk_ready("full_held1", 1'b1, 1'b0);
        tick("full_last_alu");
        chk_ready("full_pop_no_raise", 1'b1, 1'b0);
        tick("full_first_lsb");
        chk_ready("full_room", 1'b1, 1'b1);
        tick("full_third_push");
        set_lsb(1'b0, 0, 0);
        drain(8);
    endtask
`endif

    task automatic test_flush();
        set_alu(1'b1, 4, 32'h444, 32'h40);
        set_lsb(1'b1, 8, 32'h888);
        tick("flush_fill");
        set_alu(1'b1, 9, 32'h999, 32'h90);
        set_lsb(1'b0, 0, 0);
        clear = 1'b1;
        #1;
        chk_ready("flush_ready", 1'b0, 1'b0);
        tick("flush_edge");
        clear = 1'b0;
        set_alu(1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("flush_quiet");
        set_alu(1'b1, 6, 32'h666, 32'h60);
        exp_q.push_back(mk(0, 6, 32'h666, 32'h60));
        tick("flush_repush");
        set_alu(1'b0, 0, 0, 0);
        drain(5);
    endtask

    task automatic test_stall_tag0();
        exp_q.push_back(mk(0, 7, 32'h777, 32'h70));
`ifdef CDB_ROUND_ROBIN_EN
        exp_q.push_back(mk(1, 12, 32'hCCC, 0));
        exp_q.push_back(mk(0, 8, 32'h888, 32'h80));
`else
        exp_q.push_back(mk(0, 8, 32'h888, 32'h80));
        exp_q.push_back(mk(1, 12, 32'hCCC, 0));
`endif
        set_alu(1'b1, 7, 32'h777, 32'h70);
        set_lsb(1'b1, 12, 32'hCCC);
        tick("stall_push1");
        set_alu(1'b1, 8, 32'h888, 32'h80);
        set_lsb(1'b0, 0, 0);
        tick("stall_push2");
        set_alu(1'b0, 0, 0, 0);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_ready("stall_ready", 1'b0, 1'b0);
            tick("stall_frozen");
        end
        rdy_in = 1'b1;
        drain(8);
        set_alu(1'b1, 0, 32'hDEAD, 32'hBEEF);
        set_lsb(1'b1, 0, 32'hF00D);
        chk_ready("tag0_ready", 1'b1, 1'b1);
        tick("tag0_accept");
        set_alu(1'b0, 0, 0, 0);
        set_lsb(1'b0, 0, 0);
        for (int i = 0; i < 3; i++) tick("tag0_quiet");
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; last_exp = '0;
        set_alu(1'b0, 0, 0, 0);
        set_lsb(1'b0, 0, 0);
        test_reset();
        test_single();
        test_contention();
`ifndef CDB_ROUND_ROBIN_EN
        test_full();
`endif
        test_flush();
        test_stall_tag0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter TAG_W, default 5, ROB tag width; tag 0 means "no tag".
REQ-002 The block SHALL have parameter DATA_W, default 32, result and npc width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 2, entries per requester queue, minimum 1.
REQ-004 The block SHALL have port clk_in, input, 1, the only clock.
REQ-005 The block SHALL have port rst_in, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port rdy_in, input, 1, global enable; low stalls the block.
REQ-007 The block SHALL have port clear, input, 1, ROB mispredict flush.
REQ-008 The block SHALL have ports alu_valid (input, 1), alu_ready (output, 1), alu_tag (input, TAG_W), alu_val (input, DATA_W) and alu_npc (input, DATA_W), the ALU requester.
REQ-009 The block SHALL have ports lsb_valid (input, 1), lsb_ready (output, 1), lsb_tag (input, TAG_W) and lsb_val (input, DATA_W), the load-result requester.
REQ-010 The block SHALL have ports cdb_valid (output, 1), cdb_tag (output, TAG_W), cdb_val (output, DATA_W), cdb_npc (output, DATA_W) and cdb_src (output, 1; 0=ALU, 1=LSB), the registered broadcast to the ROB, RS and LSB.

Function
REQ-011 Each requester SHALL own a FIFO_DEPTH-entry FIFO; ALU entries hold {tag,val,npc} and LSB entries hold {tag,val}.
REQ-012 Each x_ready output SHALL equal (count_x < FIFO_DEPTH) && rdy_in && !clear, decoded from registered state only; a pop in the same cycle SHALL NOT raise ready.
REQ-013 A transfer SHALL occur on a rising edge where x_valid && x_ready; an accepted request with tag 0 SHALL be discarded and never broadcast.
REQ-014 At most one FIFO head SHALL be popped per enabled cycle; the popped entry SHALL drive cdb_* on the following edge with cdb_valid=1.
REQ-015 In an enabled cycle with no pop, cdb_valid SHALL be 0 and cdb_tag/cdb_val/cdb_npc/cdb_src SHALL be 0.
REQ-016 Minimum latency SHALL be one cycle: a request accepted at edge N into an empty FIFO appears on cdb_* after edge N+1.
REQ-017 For an LSB broadcast, cdb_npc SHALL be 0.
REQ-018 With only one FIFO non-empty, that FIFO SHALL be granted.
REQ-019 With both FIFOs non-empty, the grant SHALL follow REQ-025/REQ-026.
REQ-020 A push and a pop on the same FIFO in the same cycle SHALL both take effect, so the count is unchanged.
REQ-021 Pointers SHALL wrap modulo FIFO_DEPTH, and FIFO order SHALL be preserved per requester.
REQ-022 When rdy_in=0 and rst_in=1, all FIFO state, the grant pointer and all cdb_* registers SHALL hold, and both readies SHALL be 0.
REQ-023 When clear=1 at an edge (rst_in=1), both FIFOs SHALL empty, the grant pointer SHALL reset, cdb_valid SHALL be 0 after that edge, and any request presented that cycle SHALL be dropped. clear takes precedence over rdy_in=0.

Reset
REQ-024 When rst_in=0 at an edge, the block SHALL set both FIFOs empty, the grant pointer to ALU-first, and every cdb_* output to 0; alu_ready and lsb_ready SHALL read 0 while rst_in=0, and reset SHALL override clear and rdy_in.

Configuration
REQ-025 With macro CDB_ROUND_ROBIN_EN defined and both FIFOs non-empty, the FIFO not granted last time SHALL be granted, and a 1-bit last-grant pointer SHALL update on every pop.
REQ-026 Without CDB_ROUND_ROBIN_EN, the ALU SHALL have fixed priority over the LSB, and no pointer register SHALL exist.

Verification
REQ-027 Reset: rst_in=0 for 2 cycles with valids high -> cdb_valid=0, both readies 0, and nothing broadcast after release until a new request arrives.
REQ-028 Single: ALU tag 3, val 0x1234, npc 0x100 accepted at edge N -> cdb_valid=1, cdb_tag=3, cdb_src=0 after edge N+1, then cdb_valid=0.
REQ-029 Contention (RR build): both FIFOs filled with two entries each (ALU tags 1,2; LSB tags 5,6) -> broadcast order 1,5,2,6. Fixed-priority build: order 1,2,5,6.
REQ-030 Full: 2 LSB pushes while ALU traffic continuously wins (fixed build) -> lsb_ready=0 until the first LSB pop; a third LSB push is held, not lost.
REQ-031 Flush: 2 entries queued, clear pulsed one cycle -> cdb_valid=0 on the next cycle, both counts 0, and the same-cycle request is never broadcast.
REQ-032 Stall and tag 0: rdy_in=0 for 3 cycles mid-drain -> cdb_* frozen and resuming in order; an accepted request with tag 0 -> no broadcast.
